// File: rtl/ysyx_24100029_issue_ctrl_pkg.sv
// Shared types for the issue controller: decoded-instruction packet, FSM states
// and default sizing of the per-register pending counters.
package ysyx_24100029_issue_ctrl_pkg;

  localparam int ISS_MAX_PEND  = 3;
  localparam int ISS_CNT_W     = 2;
  localparam int NUM_ARCH_REGS = 32;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       wr_rd;
  } rv_decode_pkt_t;

  typedef enum logic [1:0] {
    ISS_RUN    = 2'd0,
    ISS_DRAIN  = 2'd1,
    ISS_SERIAL = 2'd2
  } iss_state_e;

endpackage

// File: rtl/ysyx_24100029_scoreboard.sv
// Per-register outstanding-write counters with RAW / WAW-overflow lookup.
// All lookups read the registered counters, so a writeback only unblocks next cycle.
module ysyx_24100029_scoreboard
  import ysyx_24100029_issue_ctrl_pkg::*;
#(
  parameter int MAX_PEND = ISS_MAX_PEND,
  parameter int CNT_W    = ISS_CNT_W
) (
  input  logic           clock,
  input  logic           reset,
  input  rv_decode_pkt_t pkt,
  input  logic           issue_fire,
  input  logic           wb_valid,
  input  logic [4:0]     wb_rd,
  output logic           raw_hazard,
  output logic           waw_hazard,
  output logic           busy,
  output logic           wb_underflow
);

  localparam logic [CNT_W-1:0] PEND_MAX = MAX_PEND[CNT_W-1:0];

  logic [NUM_ARCH_REGS-1:0][CNT_W-1:0] pend_all;
  logic [NUM_ARCH_REGS-1:0]            pend_nz;

  // x0 is hard-wired empty so it can never produce a hazard.
  assign pend_all[0] = '0;
  assign pend_nz[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_ARCH_REGS; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             inc;
      logic             dec;

      assign inc = issue_fire && pkt.wr_rd && (pkt.rd == 5'(gi));
      assign dec = wb_valid && (wb_rd == 5'(gi)) && (cnt_reg != '0);

      always_comb begin
        cnt_next = cnt_reg;
        if (inc && !dec) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign pend_all[gi] = cnt_reg;
      assign pend_nz[gi]  = (cnt_reg != '0);
    end
  endgenerate

  assign raw_hazard = (pkt.use_rs1 && (pkt.rs1 != 5'd0) && (pend_all[pkt.rs1] != '0)) ||
                      (pkt.use_rs2 && (pkt.rs2 != 5'd0) && (pend_all[pkt.rs2] != '0));

  assign waw_hazard = pkt.wr_rd && (pkt.rd != 5'd0) && (pend_all[pkt.rd] == PEND_MAX);

  assign wb_underflow = wb_valid && (wb_rd != 5'd0) && (pend_all[wb_rd] == '0);

  assign busy = |pend_nz;

endmodule

// File: rtl/ysyx_24100029_issue_ctrl.sv
// Issue controller: gates decode with the scoreboard, serializes ecall/mret/fence.i,
// and keeps a saturating stall counter and a sticky writeback-error flag.
module ysyx_24100029_issue_ctrl
  import ysyx_24100029_issue_ctrl_pkg::*;
#(
  parameter int MAX_PEND = ISS_MAX_PEND,
  parameter int CNT_W    = ISS_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic        dec_wr_rd,
  input  logic        dec_serial,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        serial_done,
  input  logic        flush,
  output logic        busy,
  output logic        wb_err,
  output logic [31:0] stall_cnt
);

  rv_decode_pkt_t dec_pkt;
  iss_state_e     state_reg, state_next;
  logic           raw_hazard, waw_hazard, sb_busy, wb_underflow;
  logic           ready_int, issue_fire;
  logic           wb_err_reg;
  logic [31:0]    stall_cnt_reg;

  assign dec_pkt = '{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                     use_rs1: dec_use_rs1, use_rs2: dec_use_rs2, wr_rd: dec_wr_rd};

  ysyx_24100029_scoreboard #(
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .pkt          (dec_pkt),
    .issue_fire   (issue_fire),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .raw_hazard   (raw_hazard),
    .waw_hazard   (waw_hazard),
    .busy         (sb_busy),
    .wb_underflow (wb_underflow)
  );

  always_comb begin
    state_next = state_reg;
    ready_int  = 1'b0;
    case (state_reg)
      ISS_RUN: begin
        ready_int = !(raw_hazard || waw_hazard) && !dec_serial;
        if (dec_valid && dec_serial && !flush) begin
          state_next = ISS_DRAIN;
        end
      end
      ISS_DRAIN: begin
        // Only the serializing instruction sits at decode here; it waits for an empty scoreboard.
        ready_int = !sb_busy;
        if (flush) begin
          state_next = ISS_RUN;
        end else if (dec_valid && ready_int) begin
          state_next = ISS_SERIAL;
        end
      end
      ISS_SERIAL: begin
        if (serial_done) begin
          state_next = ISS_RUN;
        end
      end
      default: begin
        state_next = ISS_RUN;
      end
    endcase
  end

  // Reset gating keeps dec_ready low for the whole time reset is held.
  assign dec_ready  = ready_int && !flush && !reset;
  assign issue_fire = dec_valid && dec_ready && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ISS_RUN;
      wb_err_reg    <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (wb_underflow) begin
        wb_err_reg <= 1'b1;
      end
      if (dec_valid && !dec_ready && !flush && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign busy      = sb_busy;
  assign wb_err    = wb_err_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
